// File: rtl/load_unit_seq.sv
// load_unit_seq: sequential load unit; one or two aligned reads, merge, extract, extend.
// Define MISALIGN_SPLIT_EN to build the two-access path for loads that cross a word boundary.
module load_unit_seq #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [2:0]        funct,
    input  logic [ADDR_W-1:0] addr,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [XLEN-1:0]   rd_data,
    output logic              misaligned,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    // state | meaning
    // IDLE  | ready for a request
    // REQ0  | first aligned read requested, waiting for grant
    // WAIT0 | waiting for first read data
    // REQ1  | second aligned read requested (split builds only)
    // WAIT1 | waiting for second read data (split builds only)
    // DONE  | result presented until consumer accepts
    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
`ifdef MISALIGN_SPLIT_EN
        REQ1,
        WAIT1,
`endif
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         funct_q, funct_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic               ld_ready_d, rd_valid_d, misaligned_d, mem_req_d;
    logic [XLEN-1:0]    rd_data_d;
    logic [ADDR_W-1:0]  mem_addr_d;
`ifdef MISALIGN_SPLIT_EN
    logic [XLEN-1:0]    word0_q, word0_d;
`endif

    function automatic int size_of(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic logic is_illegal(input logic [2:0] f);
        return (f == 3'b111) || ((XLEN == 32) && ((f == 3'b011) || (f == 3'b110)));
    endfunction

`ifdef MISALIGN_SPLIT_EN
    function automatic logic crosses(input logic [2:0] f, input logic [OFF_W-1:0] off);
        return (int'(off) + size_of(f[1:0])) > NB;
    endfunction
`else
    function automatic logic unaligned(input logic [2:0] f, input logic [OFF_W-1:0] off);
        return (int'(off) & (size_of(f[1:0]) - 1)) != 0;
    endfunction
`endif

    // Shift the two-word window down to the addressed byte, then mask and extend.
    function automatic logic [XLEN-1:0] extract(input logic [2:0]       f,
                                                input logic [OFF_W-1:0] off,
                                                input logic [XLEN-1:0]  lo,
                                                input logic [XLEN-1:0]  hi);
        logic [2*XLEN-1:0] both;
        logic [XLEN-1:0]   merged;
        logic [XLEN-1:0]   field_mask;
        logic [XLEN-1:0]   msb_mask;
        int                nbits;
        both       = {hi, lo} >> (8 * int'(off));
        merged     = both[XLEN-1:0];
        nbits      = 8 * size_of(f[1:0]);
        field_mask = ~({XLEN{1'b1}} << nbits);
        msb_mask   = field_mask & ~(field_mask >> 1);
        if (!f[2] && ((merged & msb_mask) != '0)) return merged | ~field_mask;
        return merged & field_mask;
    endfunction

    always_comb begin
        state_d      = state_q;
        funct_d      = funct_q;
        off_d        = off_q;
        ld_ready_d   = ld_ready;
        rd_valid_d   = rd_valid;
        rd_data_d    = rd_data;
        misaligned_d = misaligned;
        mem_req_d    = mem_req;
        mem_addr_d   = mem_addr;
`ifdef MISALIGN_SPLIT_EN
        word0_d      = word0_q;
`endif
        case (state_q)
            IDLE: begin
                if (ld_valid && ld_ready) begin
                    funct_d    = funct;
                    off_d      = addr[OFF_W-1:0];
                    ld_ready_d = 1'b0;
                    if (is_illegal(funct)) begin
                        state_d      = DONE;
                        rd_valid_d   = 1'b1;
                        rd_data_d    = '0;
                        misaligned_d = 1'b0;
                    end
`ifndef MISALIGN_SPLIT_EN
                    else if (unaligned(funct, addr[OFF_W-1:0])) begin
                        state_d      = DONE;
                        rd_valid_d   = 1'b1;
                        rd_data_d    = '0;
                        misaligned_d = 1'b1;
                    end
`endif
                    else begin
                        state_d    = REQ0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    end
                end
            end
            REQ0: begin
                if (mem_gnt) begin
                    state_d   = WAIT0;
                    mem_req_d = 1'b0;
                end
            end
            WAIT0: begin
                if (mem_rvalid) begin
`ifdef MISALIGN_SPLIT_EN
                    word0_d = mem_rdata;
                    if (crosses(funct_q, off_q)) begin
                        state_d    = REQ1;
                        mem_req_d  = 1'b1;
                        mem_addr_d = mem_addr + ADDR_W'(NB);
                    end else
`endif
                    begin
                        state_d      = DONE;
                        rd_valid_d   = 1'b1;
                        rd_data_d    = extract(funct_q, off_q, mem_rdata, mem_rdata);
                        misaligned_d = 1'b0;
                    end
                end
            end
`ifdef MISALIGN_SPLIT_EN
            REQ1: begin
                if (mem_gnt) begin
                    state_d   = WAIT1;
                    mem_req_d = 1'b0;
                end
            end
            WAIT1: begin
                if (mem_rvalid) begin
                    state_d      = DONE;
                    rd_valid_d   = 1'b1;
                    rd_data_d    = extract(funct_q, off_q, word0_q, mem_rdata);
                    misaligned_d = 1'b0;
                end
            end
`endif
            DONE: begin
                if (rd_ready) begin
                    state_d      = IDLE;
                    rd_valid_d   = 1'b0;
                    rd_data_d    = '0;
                    misaligned_d = 1'b0;
                    ld_ready_d   = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                ld_ready_d = 1'b1;
                rd_valid_d = 1'b0;
                mem_req_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            funct_q    <= '0;
            off_q      <= '0;
            ld_ready   <= 1'b1;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            misaligned <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
`ifdef MISALIGN_SPLIT_EN
            word0_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            funct_q    <= funct_d;
            off_q      <= off_d;
            ld_ready   <= ld_ready_d;
            rd_valid   <= rd_valid_d;
            rd_data    <= rd_data_d;
            misaligned <= misaligned_d;
            mem_req    <= mem_req_d;
            mem_addr   <= mem_addr_d;
`ifdef MISALIGN_SPLIT_EN
            word0_q    <= word0_d;
`endif
        end
    end

endmodule

// File: tb/tb_load_unit_seq.sv
// tb_load_unit_seq: drives an XLEN=32 and an XLEN=64 load unit against a byte-addressed memory model.
// Expected results come from reading bytes at the load address and extending them.
module tb_load_unit_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        ld_valid, rd_ready, mem_gnt, mem_rvalid;
    logic [2:0]  funct;
    logic [31:0] addr;
    logic [63:0] mem_rdata;

    logic        ld_ready32, rd_valid32, mis32, mem_req32;
    logic [31:0] rd_data32, mem_addr32;
    logic        ld_ready64, rd_valid64, mis64, mem_req64;
    logic [63:0] rd_data64;
    logic [31:0] mem_addr64;

    logic        ld_ready_m, rd_valid_m, mis_m, mem_req_m;
    logic [63:0] rd_data_m;
    logic [31:0] mem_addr_m;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    load_unit_seq #(.XLEN(32), .ADDR_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid & ~sel), .ld_ready(ld_ready32),
        .funct(funct), .addr(addr),
        .rd_valid(rd_valid32), .rd_ready(rd_ready & ~sel),
        .rd_data(rd_data32), .misaligned(mis32),
        .mem_req(mem_req32), .mem_addr(mem_addr32),
        .mem_gnt(mem_gnt & ~sel), .mem_rvalid(mem_rvalid & ~sel),
        .mem_rdata(mem_rdata[31:0])
    );

    load_unit_seq #(.XLEN(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid & sel), .ld_ready(ld_ready64),
        .funct(funct), .addr(addr),
        .rd_valid(rd_valid64), .rd_ready(rd_ready & sel),
        .rd_data(rd_data64), .misaligned(mis64),
        .mem_req(mem_req64), .mem_addr(mem_addr64),
        .mem_gnt(mem_gnt & sel), .mem_rvalid(mem_rvalid & sel),
        .mem_rdata(mem_rdata)
    );

    assign ld_ready_m = sel ? ld_ready64 : ld_ready32;
    assign rd_valid_m = sel ? rd_valid64 : rd_valid32;
    assign mis_m      = sel ? mis64      : mis32;
    assign mem_req_m  = sel ? mem_req64  : mem_req32;
    assign rd_data_m  = sel ? rd_data64  : {32'h0, rd_data32};
    assign mem_addr_m = sel ? mem_addr64 : mem_addr32;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        if (mem.exists(a)) return mem[a];
        h = (a ^ 32'h9E37_79B9) * 32'h0100_0193;
        return h[20:13];
    endfunction

    function automatic logic [63:0] mem_word(input bit wide, input logic [31:0] wa);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < (wide ? 8 : 4); i++) w[8*i +: 8] = mem_byte(wa + 32'(i));
        return w;
    endfunction

    task automatic put_bytes(input logic [31:0] a, input logic [63:0] d, input int n);
        for (int i = 0; i < n; i++) mem[a + 32'(i)] = d[8*i +: 8];
    endtask

    // Reference: the load reads size bytes starting at addr, little-endian, then extends.
    function automatic void model(input bit wide, input logic [2:0] f, input logic [31:0] a,
                                  output logic [63:0] d, output bit mis, output int nreq,
                                  output logic [31:0] a0, output logic [31:0] a1);
        int          nb, size, off;
        logic [63:0] v;
        bit          illegal;
        nb      = wide ? 8 : 4;
        size    = 1 << f[1:0];
        off     = int'(a[2:0]) % nb;
        illegal = (f == 3'b111) || (!wide && (f == 3'b011 || f == 3'b110));
        a0      = a - 32'(off);
        a1      = a0 + 32'(nb);
        d       = '0;
        mis     = 1'b0;
        nreq    = 0;
        if (illegal) return;
`ifndef MISALIGN_SPLIT_EN
        if ((int'(a[2:0]) % size) != 0) begin
            mis = 1'b1;
            return;
        end
`endif
        nreq = (off + size > nb) ? 2 : 1;
        v = '0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = mem_byte(a + 32'(i));
        if (!f[2] && size < 8 && ((v >> (8*size - 1)) & 64'd1) != 0) v = v | (~64'd0 << (8*size));
        if (!wide) v[63:32] = '0;
        d = v;
    endfunction

    task automatic run_load(input bit wide, input logic [2:0] f, input logic [31:0] a,
                            input int gnt_dly, input int rv_dly, input int rdy_dly,
                            output logic [63:0] got);
        logic [63:0] exp_data, held;
        logic [31:0] a0, a1;
        bit          exp_mis, pending, done;
        int          exp_nreq, nreq, gwait, rwait, cyc;
        model(wide, f, a, exp_data, exp_mis, exp_nreq, a0, a1);
        got = '0;
        @(negedge clk);
        sel        = wide;
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = {$urandom, $urandom};
        #1;
        check_eq("ld_ready_idle", ld_ready_m, 1);
        ld_valid = 1'b1;
        funct    = f;
        addr     = a;
        @(negedge clk);
        ld_valid = 1'b0;
        funct    = 3'($urandom);
        addr     = $urandom;
        nreq = 0; gwait = 0; rwait = 0; pending = 1'b0; done = 1'b0; cyc = 0;
        while (!done && cyc < 100) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = {$urandom, $urandom};
            if (rd_valid_m) begin
                if (gnt_dly == 0 && rv_dly == 0) check_eq("latency", cyc, 2*exp_nreq);
                check_eq("rd_data", rd_data_m, exp_data);
                check_eq("misaligned", mis_m, exp_mis);
                check_eq("mem_reqs", nreq, exp_nreq);
                got  = rd_data_m;
                held = rd_data_m;
                for (int k = 0; k < rdy_dly; k++) begin
                    @(negedge clk);
                    check_eq("rd_hold", rd_data_m, held);
                    check_eq("busy_flags", {rd_valid_m, ld_ready_m, mem_req_m}, 3'b100);
                end
                rd_ready = 1'b1;
                @(negedge clk);
                rd_ready = 1'b0;
                check_eq("rd_release", {rd_valid_m, ld_ready_m}, 2'b01);
                done = 1'b1;
            end else begin
                check_eq("ld_ready_busy", ld_ready_m, 0);
                if (mem_req_m) begin
                    if (nreq < exp_nreq) check_eq("mem_addr", mem_addr_m, (nreq == 0) ? a0 : a1);
                    else check_eq("mem_req_count", nreq + 1, exp_nreq);
                    if (gwait >= gnt_dly) begin
                        mem_gnt = 1'b1;
                        nreq++;
                        gwait   = 0;
                        rwait   = 0;
                        pending = 1'b1;
                    end else begin
                        gwait++;
                    end
                end else if (pending) begin
                    if (rwait >= rv_dly) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = mem_word(wide, (nreq == 1) ? a0 : a1);
                        pending    = 1'b0;
                    end else begin
                        rwait++;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        check_eq("rd_valid_seen", done, 1);
    endtask

    initial begin
        logic [63:0] got;
        logic [2:0]  f;
        logic [31:0] a;
        rst_n = 1'b0; sel = 1'b0; ld_valid = 1'b0; rd_ready = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; funct = '0; addr = '0; mem_rdata = '0;
        put_bytes(32'h100, 64'h8012_3456, 4);
        put_bytes(32'h200, 64'hBEEF_1234, 4);
        put_bytes(32'h300, 64'h4433_2211, 4);
        put_bytes(32'h304, 64'h8877_6655, 4);
        put_bytes(32'h408, 64'h8877_6655_4433_2211, 8);

        repeat (2) @(negedge clk);
        check_eq("rst_ld_ready32", ld_ready32, 1);
        check_eq("rst_flags32", {rd_valid32, mis32, mem_req32}, 3'b000);
        check_eq("rst_data32", {rd_data32, mem_addr32}, 64'h0);
        check_eq("rst_ld_ready64", ld_ready64, 1);
        check_eq("rst_flags64", {rd_valid64, mis64, mem_req64}, 3'b000);
        check_eq("rst_data64", rd_data64 | {32'h0, mem_addr64}, 64'h0);
        rst_n = 1'b1;

        run_load(1'b0, 3'b000, 32'h103, 0, 0, 0, got);
        check_eq("lb_0x103", got, 64'hFFFF_FF80);
        run_load(1'b0, 3'b101, 32'h202, 0, 0, 0, got);
        check_eq("lhu_0x202", got, 64'h0000_BEEF);
        run_load(1'b0, 3'b001, 32'h202, 0, 0, 0, got);
        check_eq("lh_0x202", got, 64'hFFFF_BEEF);
        run_load(1'b0, 3'b010, 32'h301, 0, 0, 1, got);
`ifdef MISALIGN_SPLIT_EN
        check_eq("lw_split", got, 64'h5544_3322);
`else
        check_eq("lw_split", got, 64'h0);
`endif
        run_load(1'b0, 3'b010, 32'h100, 4, 1, 3, got);
        check_eq("lw_backpressure", got, 64'h8012_3456);
        run_load(1'b0, 3'b111, 32'h100, 0, 0, 2, got);
        check_eq("illegal_111", got, 64'h0);

        // Reset while waiting for read data, then a stale response.
        @(negedge clk);
        sel = 1'b0; ld_valid = 1'b1; funct = 3'b010; addr = 32'h100;
        @(negedge clk);
        ld_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check_eq("pre_rst_busy", {ld_ready_m, mem_req_m}, 2'b00);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_flags", {ld_ready_m, rd_valid_m, mis_m, mem_req_m}, 4'b1000);
        check_eq("mid_rst_data", rd_data_m | {32'h0, mem_addr_m}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = {$urandom, $urandom};
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_eq("stale_rvalid", {ld_ready_m, rd_valid_m, mem_req_m}, 3'b100);
        @(negedge clk);
        check_eq("stale_quiet", {rd_valid_m, rd_data_m[31:0]}, 33'h0);
        run_load(1'b0, 3'b010, 32'h100, 0, 0, 0, got);
        check_eq("lw_after_rst", got, 64'h8012_3456);

        run_load(1'b1, 3'b011, 32'h408, 0, 0, 0, got);
        check_eq("ld_0x408", got, 64'h8877_6655_4433_2211);
        run_load(1'b1, 3'b110, 32'h40C, 0, 0, 0, got);
        check_eq("lwu_0x40c", got, 64'h0000_0000_8877_6655);
        run_load(1'b1, 3'b010, 32'h40C, 1, 0, 0, got);
        check_eq("lw64_0x40c", got, 64'hFFFF_FFFF_8877_6655);

        for (int i = 0; i < 200; i++) begin
            f = 3'($urandom);
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else a = 32'h0000_1000 + 32'($urandom_range(0, 255));
            run_load(1'($urandom), f, a, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/load_unit_seq.md
Name: load_unit_seq

Overview:
Sequential, parametrised load unit for the core's memory stage.
- Accepts a load request (funct, byte address) over a valid/ready handshake.
- Issues one or two aligned reads on the data-memory port and merges the returned words.
- Extracts the addressed byte/half/word/double, sign- or zero-extends it, and returns the result over a second valid/ready handshake.
- Supports XLEN=32 (RV32I loads) and XLEN=64 (adds LD/LWU).

Parameters:
XLEN, 32, data width; legal values 32 or 64.
ADDR_W, 32, byte-address width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
ld_valid  in  1  load request valid.
ld_ready  out  1  unit idle and able to accept a request.
funct  in  3  RISC-V load funct3: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
addr  in  ADDR_W  byte address of the load.
rd_valid  out  1  result valid.
rd_ready  in  1  consumer accepts result.
rd_data  out  XLEN  extended load result.
misaligned  out  1  fault flag; qualified by rd_valid.
mem_req  out  1  memory read request.
mem_addr  out  ADDR_W  aligned read address (low log2(XLEN/8) bits = 0).
mem_gnt  in  1  memory accepts mem_req this cycle.
mem_rvalid  in  1  read data valid.
mem_rdata  in  XLEN  read data.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - ld_ready=1 once in IDLE; rd_valid=0, rd_data=0, misaligned=0, mem_req=0, mem_addr=0.
  - All outputs are registered.
- Request capture: funct and addr are registered on the cycle ld_valid&&ld_ready. Later changes on these inputs are ignored.
- Decode:
  - Size = 1 << funct[1:0] bytes; funct[2]=1 selects zero-extension.
  - off = addr mod (XLEN/8).
  - Illegal funct: 111 always; 011/110 when XLEN=32; 011 with funct[2]=1 (i.e. 111).
- State machine:
  - IDLE: ld_ready=1. On accept:
    - Illegal funct -> DONE with rd_data=0, misaligned=0, no memory access.
    - Otherwise -> REQ0.
  - REQ0: mem_req=1, mem_addr=aligned(addr). Held stable until mem_gnt; then -> WAIT0.
  - WAIT0: on mem_rvalid, capture word0.
    - If off+size > XLEN/8 (crossing) -> REQ1.
    - Otherwise -> DONE.
  - REQ1: mem_req=1, mem_addr=aligned(addr)+XLEN/8 (wraps modulo 2^ADDR_W). On mem_gnt -> WAIT1.
  - WAIT1: on mem_rvalid, capture word1 -> DONE.
  - DONE: rd_valid=1. rd_data and misaligned are held stable until rd_ready; then -> IDLE with rd_valid=0. No same-cycle re-accept.
- Data path:
  - merged = {word1, word0} >> (8*off), using only the low XLEN bits.
  - Field = low 8*size bits of merged.
  - Extension: sign-extend from the field MSB when funct[2]=0, otherwise zero-extend. LW on XLEN=64 sign-extends from bit 31.
- Timing:
  - mem_rvalid arrives no earlier than the cycle after mem_gnt.
  - mem_rvalid in IDLE/REQx/DONE is ignored; this covers stale responses after reset.
  - Best-case aligned latency: accept at T, mem_gnt at T+1, mem_rvalid at T+2, rd_valid at T+3.
- Reset mid-operation: request is abandoned and the unit returns to IDLE immediately. No result is produced.

Optional Feature:
MISALIGN_SPLIT_EN
- Defined: crossing loads use the REQ1/WAIT1 two-access path described above. misaligned is always 0.
- Undefined: REQ1/WAIT1 are not built. A crossing load (off+size > XLEN/8) or any load with off not a multiple of size goes from IDLE directly to DONE with misaligned=1, rd_data=0, and no mem_req.

Test Plan:
1. XLEN=32, LB addr=0x103, mem_rdata=0x80123456 -> mem_addr=0x100, rd_data=0xFFFFFF80, rd_valid at accept+3.
2. LHU addr=0x202, mem_rdata=0xBEEF1234 -> rd_data=0x0000BEEF. LH same stimulus -> 0xFFFFBEEF.
3. MISALIGN_SPLIT_EN defined: LW addr=0x301, words 0x44332211 @0x300 and 0x88776655 @0x304 -> two requests (0x300, then 0x304), rd_data=0x55443322, misaligned=0. Same stimulus with macro undefined -> no mem_req, misaligned=1, rd_data=0.
4. Backpressure: mem_gnt held low 4 cycles (mem_req/mem_addr stable); rd_ready held low 3 cycles after rd_valid -> rd_data stable, ld_ready=0 throughout. Illegal funct=111 -> rd_data=0, no mem_req.
5. Reset: assert rst_n=0 during WAIT0, release, then drive a stale mem_rvalid -> outputs zero, state IDLE, no rd_valid. A fresh LW then completes normally.
6. XLEN=64: LD addr=0x408, mem_rdata=0x8877665544332211 -> rd_data equal to it. LWU addr=0x40C -> 0x0000000088776655. LW addr=0x40C -> 0xFFFFFFFF88776655.
